// File: rtl/sign_narrow.sv
// sign_narrow
// Narrows signed IN_W-bit words to OUT_W bits, either wrapping (truncation)
// or saturating to the nearest OUT_W-bit extreme. Results go through a
// 2-entry FIFO. A saturating counter records how many accepted words did
// not fit in OUT_W signed bits.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   in_valid/in_ready  input handshake, in_data (IN_W) and mode travel with it
//   mode               0 = wrap, 1 = saturate (sampled on the accept cycle)
//   out_valid/out_ready output handshake; out_data (OUT_W) and out_ovf
//                      come from the FIFO head
//   clr_count          synchronous clear of ovf_count (wins over increment)
//   ovf_count          saturating count of accepted overflowing words
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready;
// a result is delivered on a rising edge where out_valid && out_ready. The
// producer must hold in_data/mode while in_valid is high and in_ready low.
// out_valid/out_data/out_ovf stay stable until delivered.
//
// OUT_W must be strictly less than IN_W.
module sign_narrow #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  // Bits that must all match the result sign bit for the value to fit.
  localparam int TOP_W = IN_W - OUT_W + 1;

  logic [OUT_W:0]   mem [2];   // {ovf, data}
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             rdy_q;     // low in reset, set by the first clock after
  logic             acc;
  logic             del;
  logic             ovf;
  logic [TOP_W-1:0] top;
  logic [OUT_W-1:0] res;

  assign top = in_data[IN_W-1:OUT_W-1];
  assign ovf = !((top == '0) || (top == '1));

  always_comb begin
    res = in_data[OUT_W-1:0];
    if (ovf && mode) begin
      if (in_data[IN_W-1]) res = {1'b1, {(OUT_W-1){1'b0}}};
      else                 res = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // No bypass: a full FIFO refuses input even when the head leaves this cycle.
  assign in_ready  = rdy_q && (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign acc       = in_valid && in_ready;
  assign del       = out_valid && out_ready;

  // Outputs forced to zero when empty so reset clears them without an edge.
  assign out_data = out_valid ? mem[rd_ptr][OUT_W-1:0] : '0;
  assign out_ovf  = out_valid ? mem[rd_ptr][OUT_W]     : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (acc) wr_ptr <= ~wr_ptr;
      if (del) rd_ptr <= ~rd_ptr;
      case ({acc, del})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through occ.
  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= {ovf, res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (acc && ovf && (ovf_count != '1)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
module tb_sign_narrow;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  sign_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .clr_count(clr_count), .ovf_count(ovf_count)
  );

  // scoreboard / reference model
  logic [OUT_W:0] exp_q[$];   // {ovf, data}
  int  m_cnt = 0;
  bit  m_rdy = 0;
  int  passed = 0;
  int  total = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: decide by the numeric value whether it fits in OUT_W bits.
  function automatic logic [OUT_W:0] ref_fn(bit m, logic [IN_W-1:0] d);
    longint v;
    bit fits;
    logic [OUT_W-1:0] r;
    v = longint'($signed(d));
    fits = (v >= -(longint'(1) << (OUT_W-1))) && (v < (longint'(1) << (OUT_W-1)));
    if (fits || !m) r = d[OUT_W-1:0];
    else if (v < 0) r = 16'h8000;
    else r = 16'h7FFF;
    return {!fits, r};
  endfunction

  // One clock: check outputs at the falling edge against the model, then
  // advance the model by what the rising edge will do.
  task automatic cycle();
    bit acc, del;
    logic [OUT_W:0] e;
    @(negedge clk);
    check("in_ready", in_ready, m_rdy && exp_q.size() < 2);
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0][OUT_W-1:0]);
      check("out_ovf", out_ovf, exp_q[0][OUT_W]);
    end
    check("ovf_count", ovf_count, m_cnt);
    acc = in_valid && m_rdy && exp_q.size() < 2;
    del = out_ready && exp_q.size() > 0;
    if (del) void'(exp_q.pop_front());
    e = ref_fn(mode, in_data);
    if (acc) exp_q.push_back(e);
    if (clr_count) m_cnt = 0;
    else if (acc && e[OUT_W] && m_cnt < CMAX) m_cnt++;
    m_rdy = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_ovf"}, out_ovf, 0);
    check({tag, "_ovf_count"}, ovf_count, 0);
  endtask

  // Accept one word into an empty FIFO, then check the result one cycle later.
  task automatic single(bit m, logic [IN_W-1:0] d, logic [OUT_W-1:0] ed, bit eo);
    mode = m; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("single_data", out_data, ed);
    check("single_ovf", out_ovf, eo);
    cycle();
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0: return IN_W'($urandom);
      1: return IN_W'(signed'($urandom_range(0, 65535)) - 32768);
      2: return IN_W'(signed'($urandom_range(0, 8)) + 32763);
      default: return IN_W'(-signed'($urandom_range(0, 8)) - 32764);
    endcase
  endfunction

  initial begin
    // reset state
    #1;
    check_reset_outputs("reset");
    #20;
    release_reset();
    check("ready_after_reset", in_ready, 1);

    // simple value
    single(0, 32'h0000000F, 16'h000F, 0);
    check("simple_count", ovf_count, 0);

    // overflow saturation and wrap
    single(1, 32'h00008000, 16'h7FFF, 1);
    single(1, 32'h80000000, 16'h8000, 1);
    single(0, 32'h00008000, 16'h8000, 1);
    check("ovf_count_3", ovf_count, 3);

    // representable boundaries in both modes
    for (int m = 0; m < 2; m++) begin
      single(m[0], 32'hFFFF8000, 16'h8000, 0);
      single(m[0], 32'h00007FFF, 16'h7FFF, 0);
      single(m[0], 32'hFFFFFFFF, 16'hFFFF, 0);
    end

    // backpressure: A, B fill the FIFO, C is held
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0;
    in_data = 32'h0000_1111; cycle();
    in_data = 32'h0000_2222; cycle();
    in_data = 32'h0000_3333;
    check("bp_full_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_stall_data", out_data, 16'h1111);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_second", out_data, 16'h2222);
    cycle();
    in_valid = 1'b0;
    check("bp_third", out_data, 16'h3333);
    cycle();
    check("bp_empty", out_valid, 0);

    // saturating counter
    in_valid = 1'b1; out_ready = 1'b1; mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = (i % 2) ? 32'h7000_0000 : 32'h8000_1234;
      cycle();
    end
    check("cnt_sat", ovf_count, CMAX);
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0; in_valid = 1'b0;
    check("cnt_clr", ovf_count, 0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode      = $urandom_range(0, 1);
      clr_count = ($urandom_range(0, 31) == 0);
      in_data   = rand_word();
      cycle();
    end
    clr_count = 1'b0;

    // reset mid-stream with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b1;
    while (exp_q.size() < 2) begin
      in_data = 32'h9000_0000;
      cycle();
    end
    check("pre_reset_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete(); m_cnt = 0; m_rdy = 0;
    #12;
    release_reset();
    in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0; in_data = 32'h0000_0042;
    cycle();
    in_valid = 1'b0;
    check("post_reset_data", out_data, 16'h0042);
    check("post_reset_valid", out_valid, 1);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

endmodule
